// File: rtl/warp_dispatcher_if.sv
// Warp dispatcher bus: launcher, yield, issue and circular_buffer sides in one bundle.
interface warp_dispatcher_if #(
    parameter int SIZE   = 8,
    parameter int WARP_W = 8
);
    localparam int CNT_W = $clog2(SIZE + 1);

    logic              launch_valid;
    logic [WARP_W-1:0] launch_warp;
    logic              launch_ready;
    logic              yield_valid;
    logic [WARP_W-1:0] yield_warp;
    logic              yield_ready;
    logic              issue_valid;
    logic [WARP_W-1:0] issue_warp;
    logic              issue_ready;
    logic              buf_push;
    logic              buf_pop;
    logic              buf_read;
    logic [WARP_W-1:0] buf_data_in;
    logic [WARP_W-1:0] buf_data_out;
    logic              buf_full;
    logic [CNT_W-1:0]  occupancy;

    modport master (
        input  launch_valid, launch_warp, yield_valid, yield_warp, issue_ready,
               buf_data_out, buf_full,
        output launch_ready, yield_ready, issue_valid, issue_warp,
               buf_push, buf_pop, buf_read, buf_data_in, occupancy
    );

    modport slave (
        output launch_valid, launch_warp, yield_valid, yield_warp, issue_ready,
               buf_data_out, buf_full,
        input  launch_ready, yield_ready, issue_valid, issue_warp,
               buf_push, buf_pop, buf_read, buf_data_in, occupancy
    );
endinterface

// File: rtl/warp_dispatcher.sv
// Sole master of a circular_buffer warp queue: pushes launched/yielded warps, issues the head.
// Optional DISPATCH_STATS_EN adds saturating issued_cnt / stall_cnt outputs.
module warp_dispatcher #(
    parameter int SIZE   = 8,
    parameter int WARP_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    warp_dispatcher_if.master    bus
`ifdef DISPATCH_STATS_EN
    ,
    output logic [15:0]          issued_cnt,
    output logic [15:0]          stall_cnt
`endif
);
    localparam int CNT_W = $clog2(SIZE + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic              run_q;
    logic              push_q;
    logic [WARP_W-1:0] push_data_q;
    logic [WARP_W-1:0] issue_warp_q;

    logic full, pop, yield_acc, launch_acc, accept;

    // run_q keeps both readies low while reset is asserted and for the first cycle after.
    assign full       = (occ_q == CNT_W'(SIZE)) || bus.buf_full;
    assign pop        = (state_q == S_ISSUE) && bus.issue_ready;
    assign bus.yield_ready  = run_q && !full && !pop;
    assign bus.launch_ready = run_q && !full && !pop && !bus.yield_valid;
    assign yield_acc  = bus.yield_valid && bus.yield_ready;
    assign launch_acc = bus.launch_valid && bus.launch_ready;
    assign accept     = yield_acc || launch_acc;

    assign bus.buf_push    = push_q;
    assign bus.buf_data_in = push_data_q;
    assign bus.buf_pop     = pop;
    assign bus.buf_read    = (state_q == S_FETCH);
    assign bus.issue_valid = (state_q == S_ISSUE);
    assign bus.issue_warp  = issue_warp_q;
    assign bus.occupancy   = occ_q;

    // Occupancy counts a word from its buf_push cycle; FETCH is at least one cycle later,
    // so the pushed word is already in the buffer when it is read.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        occ_d   = occ_q;
        unique case (state_q)
            S_IDLE:  if (occ_q != '0) state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_ISSUE;
            S_ISSUE: if (bus.issue_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept)   occ_d = occ_q + CNT_W'(1);
        else if (pop) occ_d = occ_q - CNT_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            occ_q        <= '0;
            run_q        <= 1'b0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
            issue_warp_q <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            run_q   <= 1'b1;
            push_q  <= accept;
            if (accept) push_data_q <= yield_acc ? bus.yield_warp : bus.launch_warp;
            if (state_q == S_WAIT) issue_warp_q <= bus.buf_data_out;
        end
    end

`ifdef DISPATCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (pop && issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 16'd1;
            if (bus.issue_valid && !bus.issue_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule
